pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Program-counter and next-PC stage of the RV32I single-cycle core; sits directly downstream of the ALU.
- Consumes the ALU result, zero flag and bit-0 flag.
- Resolves conditional branches, JAL and JALR; holds the architectural PC register.
- Raises a sticky trap on misaligned control-flow targets and keeps a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset (0 = reset)
stall  input  1  hold PC and counter this cycle
branch  input  1  current instruction is a conditional branch
jump  input  1  current instruction is JAL
jalr  input  1  current instruction is JALR
br_funct3  input  3  branch funct3 field
zero  input  1  ALU result == 0
last_bit  input  1  ALU result bit 0 (SLT/SLTU outcome)
imm  input  32  sign-extended B/J immediate
alu_result  input  32  ALU output (JALR target rs1+imm)
pc  output  32  current PC
pc_plus4  output  32  pc + 4, combinational, wraps mod 2^32 (JAL/JALR link value)
take  output  1  combinational: control transfer taken this cycle
instr_valid  output  1  high when state is RUN
misalign_trap  output  1  high when state is TRAP
bad_target  output  32  faulting target captured on trap
instret  output  32  retired-instruction count

Behaviour:
- Reset: on any rising edge with rst=0, regardless of state:
  - pc=RESET_PC, state=BOOT, bad_target=0, instret=0.
  - Outputs therefore read instr_valid=0, misalign_trap=0.
  - Reset mid-trap or mid-stall is fully honoured.
- FSM states: BOOT, RUN, TRAP.
  - BOOT: exactly one cycle after rst released. pc holds RESET_PC, instret holds. Next edge goes to RUN unconditionally; stall is ignored.
  - RUN: normal operation, see update rules below.
  - TRAP: terminal; pc, instret and bad_target all frozen. Exit only via reset.
- Branch condition (cond), from br_funct3:
  - 000 BEQ: zero.
  - 001 BNE: !zero.
  - 100 BLT / 110 BLTU: last_bit.
  - 101 BGE / 111 BGEU: !last_bit.
  - 010 / 011: 0.
- Target and take priority (first match wins):
  - jalr: target = alu_result & ~32'h1; take=1.
  - jump: target = pc + imm; take=1.
  - branch: target = pc + imm; take=cond.
  - none: take=0, next = pc_plus4.
  - Adds are 32-bit and wrap mod 2^32; no overflow detection.
  - take is combinational from inputs and is not gated by state.
- Misaligned target: misaligned = take && (target[1:0] != 2'b00). JALR bit 0 is already cleared, so only bit 1 can fault.
- RUN update on each rising edge:
  - stall=1: pc, instret and state hold. A misaligned target is not trapped while stalled.
  - stall=0, misaligned=1: pc holds (faulting instruction not retired), bad_target = target, state goes to TRAP, instret holds.
  - stall=0, otherwise: pc = take ? target : pc_plus4, instret = instret + 1. instret wraps 32'hFFFF_FFFF to 0.
- Latency: the new PC is visible the cycle after the edge on which it is computed. There is no internal pipelining.

Test Plan:
- Reset/boot: hold rst=0 for 2 cycles, release, stall=0, no control inputs -> pc 0 (BOOT, instr_valid=0), then 0 (RUN, instr_valid=1), then 4, then 8; instret reads 0,0,1,2.
- Branch decode: pc=0x100, imm=0x20, branch=1.
  - br_funct3=000, zero=1 -> take=1, next pc 0x120.
  - br_funct3=000, zero=0 -> next pc 0x104.
  - br_funct3=101, last_bit=1 -> next pc 0x104.
  - br_funct3=010 with either flag -> next pc 0x104.
- Jump priority: pc=0x200, jump=1, jalr=1, alu_result=0x1235, imm=0x40 -> jalr wins; next pc 0x1234; pc_plus4 was 0x204 in the prior cycle.
- Misalign trap: pc=0x300, jump=1, imm=0x6.
  - Stall=1 for one cycle -> no trap, pc holds 0x300.
  - Stall=0 -> misalign_trap=1, bad_target=0x306, pc stays 0x300, instret unchanged.
  - Further clocks with any inputs -> everything frozen.
  - rst=0 for one edge -> pc=RESET_PC, misalign_trap=0.
- Wrap-around:
  - Force pc=0xFFFF_FFFC via RESET_PC override; step -> pc=0x0000_0000.
  - Branch with pc=0x10, imm=0xFFFF_FFF0 -> pc=0x0.
  - instret preloaded near 0xFFFF_FFFF via long run or bind force -> increments to 0.
- Stall hold: in RUN at pc=0x40, assert stall for 3 cycles with jump=1, imm=0x100 -> pc stays 0x40 and instret unchanged; deassert -> pc=0x140.

Source files
------------

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - RV32I program counter, next-PC selection, misalign trap and retired-instruction counter
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        jalr,
  input  logic [2:0]  br_funct3,
  input  logic        zero,
  input  logic        last_bit,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        take,
  output logic        instr_valid,
  output logic        misalign_trap,
  output logic [31:0] bad_target,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] bad_target_q, bad_target_d;

  logic        cond;
  logic [31:0] target;
  logic [31:0] rel_target;
  logic        misaligned;

  // Branch condition from funct3; SLT/SLTU outcome arrives on last_bit.
  always_comb begin
    cond = 1'b0;
    unique case (br_funct3)
      3'b000:         cond = zero;
      3'b001:         cond = ~zero;
      3'b100, 3'b110: cond = last_bit;
      3'b101, 3'b111: cond = ~last_bit;
      default:        cond = 1'b0;
    endcase
  end

  assign pc_plus4   = pc_q + 32'd4;
  assign rel_target = pc_q + imm;

  // Target/take selection: JALR beats JAL beats conditional branch.
  always_comb begin
    target = pc_plus4;
    take   = 1'b0;
    if (jalr) begin
      target = alu_result & ~32'h1;
      take   = 1'b1;
    end else if (jump) begin
      target = rel_target;
      take   = 1'b1;
    end else if (branch) begin
      target = rel_target;
      take   = cond;
    end
  end

  assign misaligned = take && (target[1:0] != 2'b00);

  // Next-state logic: BOOT lasts one cycle, RUN retires or traps, TRAP is terminal.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instret_d    = instret_q;
    bad_target_d = bad_target_q;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          if (misaligned) begin
            bad_target_d = target;
            state_d      = ST_TRAP;
          end else begin
            pc_d      = take ? target : pc_plus4;
            instret_d = instret_q + 32'd1;
          end
        end
      end
      ST_TRAP: begin
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      instret_q    <= 32'd0;
      bad_target_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instret_q    <= instret_d;
      bad_target_q <= bad_target_d;
    end
  end

  assign pc            = pc_q;
  assign instr_valid   = (state_q == ST_RUN);
  assign misalign_trap = (state_q == ST_TRAP);
  assign bad_target    = bad_target_q;
  assign instret       = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit: vector table, corner sequences, randomized model comparison
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch;
  logic        jump;
  logic        jalr;
  logic [2:0]  br_funct3;
  logic        zero;
  logic        last_bit;
  logic [31:0] imm;
  logic [31:0] alu_result;

  logic [31:0] pc, pc_plus4, bad_target, instret;
  logic        take, instr_valid, misalign_trap;
  logic [31:0] pc2, pc_plus4_2, bad_target2, instret2;
  logic        take2, instr_valid2, misalign_trap2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .jump(jump), .jalr(jalr),
    .br_funct3(br_funct3), .zero(zero), .last_bit(last_bit), .imm(imm), .alu_result(alu_result),
    .pc(pc), .pc_plus4(pc_plus4), .take(take), .instr_valid(instr_valid),
    .misalign_trap(misalign_trap), .bad_target(bad_target), .instret(instret)
  );

  pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .jump(jump), .jalr(jalr),
    .br_funct3(br_funct3), .zero(zero), .last_bit(last_bit), .imm(imm), .alu_result(alu_result),
    .pc(pc2), .pc_plus4(pc_plus4_2), .take(take2), .instr_valid(instr_valid2),
    .misalign_trap(misalign_trap2), .bad_target(bad_target2), .instret(instret2)
  );

  typedef struct {
    logic [2:0]  f3;
    logic        z;
    logic        lb;
    logic        exp_take;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; branch = 0; jump = 0; jalr = 0; br_funct3 = 3'b000;
    zero = 0; last_bit = 0; imm = 32'd0; alu_result = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge, then one BOOT edge; afterwards the core is in RUN.
  task automatic do_reset();
    clear_inputs();
    rst = 0;
    tick();
    rst = 1;
    tick();
  endtask

  // Reach a given aligned PC via a JAL from reset (instret becomes 1).
  task automatic goto_pc(input logic [31:0] addr);
    do_reset();
    jump = 1; imm = addr;
    tick();
    clear_inputs();
  endtask

  // Reference next-PC decision written straight from the instruction semantics.
  function automatic logic [32:0] ref_decide(input logic [31:0] cur_pc, input logic b, input logic j,
                                             input logic jr, input logic [2:0] f3, input logic z,
                                             input logic lb, input logic [31:0] im, input logic [31:0] alu);
    logic c;
    case (f3)
      3'd0: c = z;
      3'd1: c = !z;
      3'd4, 3'd6: c = lb;
      3'd5, 3'd7: c = !lb;
      default: c = 0;
    endcase
    if (jr) return {1'b1, alu - 32'(alu % 2)};
    if (j) return {1'b1, cur_pc + im};
    if (b && c) return {1'b1, cur_pc + im};
    return {1'b0, cur_pc + 32'd4};
  endfunction

  logic [31:0] m_pc, m_instret, m_bad;
  logic        m_booting, m_trapped;
  logic [32:0] dec;

  initial begin
    vecs[0] = '{3'b000, 1'b1, 1'b0, 1'b1, 32'h120};
    vecs[1] = '{3'b000, 1'b0, 1'b0, 1'b0, 32'h104};
    vecs[2] = '{3'b101, 1'b0, 1'b1, 1'b0, 32'h104};
    vecs[3] = '{3'b010, 1'b1, 1'b0, 1'b0, 32'h104};
    vecs[4] = '{3'b010, 1'b0, 1'b1, 1'b0, 32'h104};
    vecs[5] = '{3'b001, 1'b0, 1'b0, 1'b1, 32'h120};
    vecs[6] = '{3'b110, 1'b1, 1'b1, 1'b1, 32'h120};
    vecs[7] = '{3'b111, 1'b0, 1'b1, 1'b0, 32'h104};

    clear_inputs();
    rst = 0;
    #2;

    // Reset and boot sequence
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_trap", {31'd0, misalign_trap}, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_bad", bad_target, 32'd0);
    rst = 1;
    tick();
    check("boot_pc", pc, 32'h0);
    check("boot_valid", {31'd0, instr_valid}, 32'd1);
    check("boot_instret", instret, 32'd0);
    tick();
    check("run_pc1", pc, 32'h4);
    check("run_instret1", instret, 32'd1);
    tick();
    check("run_pc2", pc, 32'h8);
    check("run_instret2", instret, 32'd2);

    // BOOT ignores stall
    clear_inputs();
    rst = 0; tick(); rst = 1; stall = 1;
    tick();
    check("boot_stall_valid", {31'd0, instr_valid}, 32'd1);
    check("boot_stall_pc", pc, 32'h0);

    // Branch decode table
    for (int i = 0; i < 8; i++) begin
      goto_pc(32'h100);
      branch = 1; imm = 32'h20; br_funct3 = vecs[i].f3; zero = vecs[i].z; last_bit = vecs[i].lb;
      #1;
      check($sformatf("br%0d_take", i), {31'd0, take}, {31'd0, vecs[i].exp_take});
      tick();
      check($sformatf("br%0d_pc", i), pc, vecs[i].exp_pc);
      clear_inputs();
    end

    // JALR beats JAL
    goto_pc(32'h200);
    check("prio_pc_plus4", pc_plus4, 32'h204);
    jump = 1; jalr = 1; alu_result = 32'h1235; imm = 32'h40;
    #1;
    check("prio_take", {31'd0, take}, 32'd1);
    tick();
    check("prio_pc", pc, 32'h1234);

    // Misalign trap: stalled first, then taken
    goto_pc(32'h300);
    jump = 1; imm = 32'h6; stall = 1;
    tick();
    check("mis_stall_trap", {31'd0, misalign_trap}, 32'd0);
    check("mis_stall_pc", pc, 32'h300);
    stall = 0;
    tick();
    check("mis_trap", {31'd0, misalign_trap}, 32'd1);
    check("mis_valid", {31'd0, instr_valid}, 32'd0);
    check("mis_bad", bad_target, 32'h306);
    check("mis_pc", pc, 32'h300);
    check("mis_instret", instret, 32'd1);
    for (int k = 0; k < 3; k++) begin
      stall = 1'($urandom); jump = 1'($urandom); jalr = 1'($urandom); branch = 1'($urandom);
      imm = $urandom; alu_result = $urandom;
      tick();
      check("frozen_pc", pc, 32'h300);
      check("frozen_bad", bad_target, 32'h306);
      check("frozen_instret", instret, 32'd1);
      check("frozen_trap", {31'd0, misalign_trap}, 32'd1);
    end
    rst = 0;
    tick();
    rst = 1;
    check("trap_rst_pc", pc, 32'h0);
    check("trap_rst_trap", {31'd0, misalign_trap}, 32'd0);
    check("trap_rst_bad", bad_target, 32'h0);

    // PC wrap from the high reset vector
    do_reset();
    check("hi_pc", pc2, 32'hFFFF_FFFC);
    check("hi_pc_plus4", pc_plus4_2, 32'h0);
    tick();
    check("hi_wrap_pc", pc2, 32'h0);

    // Branch target wraps
    goto_pc(32'h10);
    branch = 1; br_funct3 = 3'b000; zero = 1; imm = 32'hFFFF_FFF0;
    tick();
    check("br_wrap_pc", pc, 32'h0);
    clear_inputs();

    // Retired counter wraps
    do_reset();
    force dut.instret_q = 32'hFFFF_FFFE;
    #1;
    release dut.instret_q;
    #1;
    tick();
    check("instret_ffff", instret, 32'hFFFF_FFFF);
    tick();
    check("instret_wrap", instret, 32'h0);

    // Stall holds across a pending jump
    goto_pc(32'h40);
    stall = 1; jump = 1; imm = 32'h100;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_pc", pc, 32'h40);
      check("stall_instret", instret, 32'd1);
    end
    stall = 0;
    tick();
    check("unstall_pc", pc, 32'h140);
    check("unstall_instret", instret, 32'd2);

    // Randomized run against the reference model
    do_reset();
    m_pc = 32'h0; m_instret = 0; m_bad = 0; m_booting = 0; m_trapped = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 59) != 0);
      stall = ($urandom_range(0, 4) == 0);
      branch = 1'($urandom); jump = ($urandom_range(0, 5) == 0); jalr = ($urandom_range(0, 7) == 0);
      br_funct3 = 3'($urandom); zero = 1'($urandom); last_bit = 1'($urandom);
      imm = 32'($signed(13'($urandom)) & ~13'h3);
      if ($urandom_range(0, 24) == 0) imm = imm | 32'h2;
      alu_result = $urandom & ~32'h2;
      if ($urandom_range(0, 24) == 0) alu_result = alu_result | 32'h2;
      #1;
      dec = ref_decide(m_pc, branch, jump, jalr, br_funct3, zero, last_bit, imm, alu_result);
      check("rnd_take", {31'd0, take}, {31'd0, dec[32]});
      check("rnd_pc_plus4", pc_plus4, m_pc + 32'd4);
      if (!rst) begin
        m_pc = 32'h0; m_instret = 0; m_bad = 0; m_booting = 1; m_trapped = 0;
      end else if (m_booting) begin
        m_booting = 0;
      end else if (!m_trapped && !stall) begin
        if (dec[32] && dec[1:0] != 2'b00) begin
          m_trapped = 1; m_bad = dec[31:0];
        end else begin
          m_pc = dec[31:0]; m_instret = m_instret + 1;
        end
      end
      tick();
      check("rnd_pc", pc, m_pc);
      check("rnd_instret", instret, m_instret);
      check("rnd_bad", bad_target, m_bad);
      check("rnd_trap", {31'd0, misalign_trap}, {31'd0, m_trapped});
      check("rnd_valid", {31'd0, instr_valid}, {31'd0, !m_booting && !m_trapped});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
